// File: rtl/logic_unit_pkg.sv
// Shared encodings for the registered logic unit: operation select and output buffer state.
package logic_unit_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

endpackage

// File: rtl/bitwise_op.sv
// Combinational WIDTH-bit bitwise operation decoder with Hack-style zero/negative flags.
module bitwise_op
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);

  always_comb begin
    result = a;
    unique case (op)
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = a;
      default: result = a;
    endcase
  end

  assign zr = (result == '0);
  assign ng = result[WIDTH-1];

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with accumulator operand and a 2-entry output buffer
// so writeback stalls never drop a result.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] acc
);

  state_e           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic [WIDTH-1:0] r_sec;
  logic             r_sec_zr;
  logic             r_sec_ng;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] w_a_eff;
  logic [WIDTH-1:0] w_res;
  logic             w_zr;
  logic             w_ng;
  logic             w_accept;
  logic             w_pop;

  // A clear requested alongside an accumulator op zeroes the operand before use.
  assign w_a_eff  = use_acc ? (clr_acc ? '0 : r_acc) : a;
  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = r_out_valid & out_ready;

  bitwise_op #(
    .WIDTH (WIDTH)
  ) u_bitwise_op (
    .a      (w_a_eff),
    .b      (b),
    .op     (op),
    .result (w_res),
    .zr     (w_zr),
    .ng     (w_ng)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_zr        <= 1'b1;
      r_ng        <= 1'b0;
      r_sec       <= '0;
      r_sec_zr    <= 1'b1;
      r_sec_ng    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out       <= w_res;
            r_zr        <= w_zr;
            r_ng        <= w_ng;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_out <= w_res;
            r_zr  <= w_zr;
            r_ng  <= w_ng;
          end else if (w_accept) begin
            r_sec      <= w_res;
            r_sec_zr   <= w_zr;
            r_sec_ng   <= w_ng;
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            r_out      <= r_sec;
            r_zr       <= r_sec_zr;
            r_ng       <= r_sec_ng;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // An accepted accumulator op takes priority over a plain clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= ACC_INIT;
    end else if (w_accept && use_acc) begin
      r_acc <= w_res;
    end else if (clr_acc) begin
      r_acc <= '0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;
  assign acc       = r_acc;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH 16, 32 and 1 sharing one stimulus stream.
module tb_logic_unit_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        use_acc;
  logic        clr_acc;
  logic        out_ready;
  logic [2:0]  op;
  logic [31:0] a32;
  logic [31:0] b32;

  logic        rdy16, v16, zr16, ng16;
  logic [15:0] out16, acc16;
  logic        rdy32, v32, zr32, ng32;
  logic [31:0] out32, acc32;
  logic        rdy1, v1, zr1, ng1;
  logic [0:0]  out1, acc1;

  int n_chk  = 0;
  int n_pass = 0;

  // Hand-computed results for a=FF00_00F0, b=0F0F_0FF0, ops 000..111.
  logic [31:0] exp_tab [8] = '{32'h00FF_FF0F, 32'h0F00_00F0, 32'hFF0F_0FF0, 32'hF00F_0F00,
                               32'hF0FF_FF0F, 32'h00F0_F00F, 32'h0FF0_F0FF, 32'hFF00_00F0};
  logic [31:0] e;

  always #5 clock = ~clock;

  logic_unit_pipe #(.WIDTH(16), .ACC_INIT(16'h0000)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(a32[15:0]), .b(b32[15:0]), .op(op), .use_acc(use_acc), .clr_acc(clr_acc),
    .out_valid(v16), .out_ready(out_ready), .out(out16), .zr(zr16), .ng(ng16), .acc(acc16)
  );

  logic_unit_pipe #(.WIDTH(32), .ACC_INIT(32'h1234_5678)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32),
    .a(a32), .b(b32), .op(op), .use_acc(use_acc), .clr_acc(clr_acc),
    .out_valid(v32), .out_ready(out_ready), .out(out32), .zr(zr32), .ng(ng32), .acc(acc32)
  );

  logic_unit_pipe #(.WIDTH(1), .ACC_INIT(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
    .a(a32[0:0]), .b(b32[0:0]), .op(op), .use_acc(use_acc), .clr_acc(clr_acc),
    .out_valid(v1), .out_ready(out_ready), .out(out1), .zr(zr1), .ng(ng1), .acc(acc1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out_all(input string tag, input logic [31:0] ev);
    chk({tag, "_out16"}, 64'(out16), 64'(ev[15:0]));
    chk({tag, "_zr16"}, 64'(zr16), 64'(ev[15:0] == 16'h0));
    chk({tag, "_ng16"}, 64'(ng16), 64'(ev[15]));
    chk({tag, "_out32"}, 64'(out32), 64'(ev));
    chk({tag, "_ng32"}, 64'(ng32), 64'(ev[31]));
    chk({tag, "_out1"}, 64'(out1), 64'(ev[0]));
    chk({tag, "_ng1"}, 64'(ng1), 64'(ev[0]));
  endtask

  task automatic chk_hs_all(input string tag, input logic vexp, input logic rexp);
    chk({tag, "_v16"}, 64'(v16), 64'(vexp));
    chk({tag, "_rdy16"}, 64'(rdy16), 64'(rexp));
    chk({tag, "_v32"}, 64'(v32), 64'(vexp));
    chk({tag, "_rdy32"}, 64'(rdy32), 64'(rexp));
    chk({tag, "_v1"}, 64'(v1), 64'(vexp));
    chk({tag, "_rdy1"}, 64'(rdy1), 64'(rexp));
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; use_acc = 1'b0; clr_acc = 1'b0; out_ready = 1'b1;
    op = 3'b000; a32 = 32'h0; b32 = 32'h0;
    #12;
    chk_hs_all("reset", 1'b0, 1'b1);
    chk("reset_out16", 64'(out16), 64'h0);
    chk("reset_zr16", 64'(zr16), 64'h1);
    chk("reset_ng16", 64'(ng16), 64'h0);
    chk("reset_acc16", 64'(acc16), 64'h0);
    chk("reset_acc32", 64'(acc32), 64'h1234_5678);
    chk("reset_acc1", 64'(acc1), 64'h1);
    reset_n = 1'b1;

    // Full op table, one result per cycle
    a32 = 32'hFF00_00F0; b32 = 32'h0F0F_0FF0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      tick();
      e = exp_tab[i];
      chk_out_all($sformatf("optab%0d", i), e);
      chk_hs_all($sformatf("optab%0d", i), 1'b1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_v16", 64'(v16), 64'h0);
    chk("drain_hold16", 64'(out16), 64'h00F0);

    // Accumulator chain, no bubble
    in_valid = 1'b1; use_acc = 1'b1; op = 3'b010; b32 = 32'h0000_0001;
    tick();
    chk("chain1_out", 64'(out16), 64'h0001);
    op = 3'b011; b32 = 32'h0000_0003;
    tick();
    chk("chain2_out", 64'(out16), 64'h0002);
    chk("chain2_acc", 64'(acc16), 64'h0002);
    chk("chain2_v", 64'(v16), 64'h1);

    // Clear-before-use, then a clear with nothing accepted
    op = 3'b010; b32 = 32'h0000_00FF;
    tick();
    chk("clr_setup_acc", 64'(acc16), 64'h00FF);
    clr_acc = 1'b1; b32 = 32'h0000_1200;
    tick();
    chk("clruse_out", 64'(out16), 64'h1200);
    chk("clruse_acc", 64'(acc16), 64'h1200);
    in_valid = 1'b0; use_acc = 1'b0;
    tick();
    chk("clronly_acc", 64'(acc16), 64'h0000);
    clr_acc = 1'b0;

    // Flags
    in_valid = 1'b1; op = 3'b001; a32 = 32'h0000_AAAA; b32 = 32'h0000_5555;
    tick();
    chk("flag_and_out", 64'(out16), 64'h0000);
    chk("flag_and_zr", 64'(zr16), 64'h1);
    chk("flag_and_ng", 64'(ng16), 64'h0);
    op = 3'b000; a32 = 32'h0;
    tick();
    chk("flag_not_out", 64'(out16), 64'hFFFF);
    chk("flag_not_zr", 64'(zr16), 64'h0);
    chk("flag_not_ng", 64'(ng16), 64'h1);
    in_valid = 1'b0;
    tick();

    // Backpressure: three sets offered while the consumer stalls
    a32 = 32'hFF00_00F0; b32 = 32'h0F0F_0FF0; out_ready = 1'b0;
    in_valid = 1'b1; op = 3'b001;
    tick();
    chk_hs_all("bp1", 1'b1, 1'b1);
    chk_out_all("bp1", exp_tab[1]);
    op = 3'b010;
    tick();
    chk_hs_all("bp2", 1'b1, 1'b0);
    chk_out_all("bp2", exp_tab[1]);
    op = 3'b011;
    tick();
    chk_hs_all("bp3", 1'b1, 1'b0);
    chk_out_all("bp3_hold", exp_tab[1]);
    out_ready = 1'b1;
    tick();
    chk_hs_all("bp4", 1'b1, 1'b1);
    chk_out_all("bp4", exp_tab[2]);
    tick();
    chk_out_all("bp5", exp_tab[3]);
    in_valid = 1'b0;
    tick();
    chk_hs_all("bp6", 1'b0, 1'b1);

    // Reset with the buffer full and the accumulator modified
    out_ready = 1'b0; in_valid = 1'b1; use_acc = 1'b1; op = 3'b010; b32 = 32'h0000_0011;
    tick();
    tick();
    chk("pre_rst_rdy16", 64'(rdy16), 64'h0);
    chk("pre_rst_acc16", 64'(acc16), 64'h0011);
    in_valid = 1'b0; use_acc = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_hs_all("midrst", 1'b0, 1'b1);
    chk("midrst_acc16", 64'(acc16), 64'h0);
    chk("midrst_acc32", 64'(acc32), 64'h1234_5678);
    chk("midrst_acc1", 64'(acc1), 64'h1);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk_hs_all("postrst", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
